// File: rtl/vga_pix_unpack.sv
`default_nettype none
// ============================================================================
// vga_pix_unpack : unpacks 32-bit video words into 24-bit RGB line-FIFO pixels
// Revision: 1.0
// ============================================================================
module vga_pix_unpack (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        ctrl_ven,
    input  logic [1:0]  ctrl_cd,
    input  logic        ctrl_pc,
    input  logic        clut_bank_i,
    input  logic [31:0] vdat_i,
    input  logic        vdat_empty_i,
    output logic        vdat_rreq_o,
    output logic        clut_req_o,
    output logic [8:0]  clut_adr_o,
    input  logic        clut_ack_i,
    input  logic [23:0] clut_q_i,
    output logic        pix_wreq_o,
    output logic [23:0] pix_d_o,
    input  logic        pix_full_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_CLUT  = 2'd3
    } state_t;

    localparam logic [1:0] CD_8  = 2'b00;
    localparam logic [1:0] CD_16 = 2'b01;
    localparam logic [1:0] CD_24 = 2'b10;

    state_t      state_q;
    logic [1:0]  cd_q;
    logic        pc_q;
    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic [1:0]  phase_q;
    logic [15:0] res_q;
    logic        pix_wreq_q;
    logic [23:0] pix_d_q;
    logic        clut_req_q;
    logic [8:0]  clut_adr_q;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [23:0] w_pix;
    logic        w_last;
    logic [1:0]  idx_d;
    logic [1:0]  phase_d;
    logic [15:0] res_d;
    state_t      adv_state_d;

    always_comb begin
        case (idx_q)
            2'd0:    w_byte = word_q[31:24];
            2'd1:    w_byte = word_q[23:16];
            2'd2:    w_byte = word_q[15:8];
            default: w_byte = word_q[7:0];
        endcase
        w_half = idx_q[0] ? word_q[15:0] : word_q[31:16];
        w_pix  = word_q[23:0];
        w_last = 1'b1;
        case (cd_q)
            CD_8: begin
                w_pix  = {w_byte, w_byte, w_byte};
                w_last = (idx_q == 2'd3);
            end
            CD_16: begin
                w_pix  = {w_half[15:11], w_half[15:13],
                          w_half[10:5],  w_half[10:9],
                          w_half[4:0],   w_half[4:2]};
                w_last = idx_q[0];
            end
            CD_24: begin
                // Phase 2 is the only phase that yields two pixels from one word
                case (phase_q)
                    2'd0:    w_pix = word_q[31:8];
                    2'd1:    w_pix = {res_q[7:0], word_q[31:16]};
                    2'd2:    w_pix = {res_q, word_q[31:24]};
                    default: w_pix = word_q[23:0];
                endcase
                w_last = (phase_q != 2'd2);
            end
            default: begin
                w_pix  = word_q[23:0];
                w_last = 1'b1;
            end
        endcase
    end

    always_comb begin
        idx_d       = w_last ? 2'd0 : idx_q + 2'd1;
        phase_d     = phase_q;
        res_d       = res_q;
        adv_state_d = w_last ? S_FETCH : S_EMIT;
        if (cd_q == CD_24) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd0 || phase_q == 2'd1) begin
                res_d = word_q[15:0];
            end
        end
    end

    assign vdat_rreq_o = (state_q == S_FETCH) & ~vdat_empty_i & ctrl_ven;
    assign clut_req_o  = clut_req_q;
    assign clut_adr_o  = clut_adr_q;
    assign pix_wreq_o  = pix_wreq_q;
    assign pix_d_o     = pix_d_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= S_IDLE;
            cd_q       <= 2'b00;
            pc_q       <= 1'b0;
            word_q     <= 32'h0;
            idx_q      <= 2'd0;
            phase_q    <= 2'd0;
            res_q      <= 16'h0;
            pix_wreq_q <= 1'b0;
            pix_d_q    <= 24'h0;
            clut_req_q <= 1'b0;
            clut_adr_q <= 9'h0;
        end else begin
            pix_wreq_q <= 1'b0;
            if (!ctrl_ven) begin
                state_q    <= S_IDLE;
                idx_q      <= 2'd0;
                phase_q    <= 2'd0;
                res_q      <= 16'h0;
                clut_req_q <= 1'b0;
                clut_adr_q <= 9'h0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cd_q    <= ctrl_cd;
                        pc_q    <= ctrl_pc;
                        state_q <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (!vdat_empty_i) begin
                            word_q  <= vdat_i;
                            state_q <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        if (!pix_full_i) begin
                            if (cd_q == CD_8 && pc_q) begin
                                clut_req_q <= 1'b1;
                                clut_adr_q <= {clut_bank_i, w_byte};
                                state_q    <= S_CLUT;
                            end else begin
                                pix_wreq_q <= 1'b1;
                                pix_d_q    <= w_pix;
                                idx_q      <= idx_d;
                                phase_q    <= phase_d;
                                res_q      <= res_d;
                                state_q    <= adv_state_d;
                            end
                        end
                    end
                    S_CLUT: begin
                        // The last lookup of a word goes straight to FETCH to keep the word rate
                        if (clut_ack_i) begin
                            clut_req_q <= 1'b0;
                            pix_wreq_q <= 1'b1;
                            pix_d_q    <= clut_q_i;
                            idx_q      <= idx_d;
                            state_q    <= adv_state_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pix_unpack.sv
`default_nettype none
// ============================================================================
// tb_vga_pix_unpack : directed scoreboard bench for vga_pix_unpack
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vga_pix_unpack;

    logic        clk_i        = 1'b0;
    logic        nrst_i       = 1'b0;
    logic        ctrl_ven     = 1'b0;
    logic [1:0]  ctrl_cd      = 2'b00;
    logic        ctrl_pc      = 1'b0;
    logic        clut_bank_i  = 1'b0;
    logic [31:0] vdat_i       = 32'h0;
    logic        vdat_empty_i = 1'b1;
    logic        clut_ack_i   = 1'b0;
    logic [23:0] clut_q_i     = 24'h0;
    logic        pix_full_i   = 1'b0;
    logic        vdat_rreq_o;
    logic        clut_req_o;
    logic [8:0]  clut_adr_o;
    logic        pix_wreq_o;
    logic [23:0] pix_d_o;

    vga_pix_unpack dut (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .ctrl_ven     (ctrl_ven),
        .ctrl_cd      (ctrl_cd),
        .ctrl_pc      (ctrl_pc),
        .clut_bank_i  (clut_bank_i),
        .vdat_i       (vdat_i),
        .vdat_empty_i (vdat_empty_i),
        .vdat_rreq_o  (vdat_rreq_o),
        .clut_req_o   (clut_req_o),
        .clut_adr_o   (clut_adr_o),
        .clut_ack_i   (clut_ack_i),
        .clut_q_i     (clut_q_i),
        .pix_wreq_o   (pix_wreq_o),
        .pix_d_o      (pix_d_o),
        .pix_full_i   (pix_full_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_rreq = 0;
    int          n_wreq = 0;
    int          ack_delay = 3;
    int          wait_cnt = 0;
    bit          force_ack = 1'b0;
    bit          rreq_pend = 1'b0;
    logic [31:0] wq[$];
    logic [23:0] exp_q[$];
    logic [8:0]  adr_q[$];
    int          wcyc[$];
    int          rcyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] clut_fn(input logic [8:0] a);
        return {8'h3C, 7'h0, a};
    endfunction

    // Show-ahead word FIFO model
    always @(posedge clk_i) begin
        cyc++;
        if (rreq_pend && wq.size() > 0) void'(wq.pop_front());
        #1;
        vdat_empty_i = (wq.size() == 0);
        vdat_i       = (wq.size() > 0) ? wq[0] : 32'h0;
    end

    // CLUT responder with configurable acknowledge delay
    always @(posedge clk_i) begin
        #1;
        clut_ack_i = 1'b0;
        if (force_ack) begin
            clut_ack_i = 1'b1;
            clut_q_i   = 24'hDEAD00;
            force_ack  = 1'b0;
        end else if (clut_req_o) begin
            if (adr_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL clut_unexpected_req: got adr %h expected no request", clut_adr_o);
            end else begin
                chk("clut_adr", {23'h0, clut_adr_o}, {23'h0, adr_q[0]});
            end
            if (wait_cnt == ack_delay) begin
                clut_ack_i = 1'b1;
                clut_q_i   = clut_fn(clut_adr_o);
                wait_cnt   = 0;
                if (adr_q.size() > 0) void'(adr_q.pop_front());
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard whenever a pixel is written
    always @(negedge clk_i) begin
        if (vdat_rreq_o) begin
            n_rreq++;
            rcyc.push_back(cyc);
        end
        rreq_pend = vdat_rreq_o;
        if (pix_wreq_o) begin
            n_wreq++;
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_pixel: got %h expected no pixel", pix_d_o);
            end else begin
                chk("pixel", {8'h0, pix_d_o}, {8'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic stop_video();
        @(posedge clk_i); #1;
        ctrl_ven = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rcyc.delete();
        wcyc.delete();
    endtask

    task automatic go(input logic [1:0] cd, input logic pc);
        ctrl_cd  = cd;
        ctrl_pc  = pc;
        ctrl_ven = 1'b1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || wq.size() != 0) && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        repeat (4) @(negedge clk_i);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    function automatic int gap(input int a, input int b);
        return b - a;
    endfunction

    initial begin
        int r0, w0, t;
        repeat (3) @(negedge clk_i);
        chk("rst_rreq",     {31'h0, vdat_rreq_o}, 0);
        chk("rst_clut_req", {31'h0, clut_req_o},  0);
        chk("rst_clut_adr", {23'h0, clut_adr_o},  0);
        chk("rst_wreq",     {31'h0, pix_wreq_o},  0);
        chk("rst_pix_d",    {8'h0, pix_d_o},      0);
        @(posedge clk_i); #1;
        nrst_i = 1'b1;

        // 32bpp
        stop_video();
        wq.push_back(32'hAA123456);
        exp_q.push_back(24'h123456);
        go(2'b11, 1'b0);
        drain("t32");
        chk("t32_latency", (wcyc.size() > 0 && rcyc.size() > 0) ? gap(rcyc[0], wcyc[0]) : -1, 2);

        // 16bpp
        stop_video();
        wq.push_back(32'hF800_07E0);
        exp_q.push_back(24'hFF0000);
        exp_q.push_back(24'h00FF00);
        go(2'b01, 1'b0);
        drain("t16");
        chk("t16_consecutive", (wcyc.size() > 1) ? gap(wcyc[0], wcyc[1]) : -1, 1);

        // 24bpp, two back-to-back triples
        stop_video();
        r0 = n_rreq; w0 = n_wreq;
        wq.push_back(32'h11223344); wq.push_back(32'h55667788); wq.push_back(32'h99AABBCC);
        wq.push_back(32'h01020304); wq.push_back(32'h05060708); wq.push_back(32'h090A0B0C);
        exp_q.push_back(24'h112233); exp_q.push_back(24'h445566);
        exp_q.push_back(24'h778899); exp_q.push_back(24'hAABBCC);
        exp_q.push_back(24'h010203); exp_q.push_back(24'h040506);
        exp_q.push_back(24'h070809); exp_q.push_back(24'h0A0B0C);
        go(2'b10, 1'b0);
        drain("t24");
        chk("t24_rreq_count", n_rreq - r0, 6);
        chk("t24_wreq_count", n_wreq - w0, 8);

        // 8bpp pseudo-color, bank 1, 3-cycle acknowledge delay
        stop_video();
        clut_bank_i = 1'b1;
        ack_delay   = 3;
        wq.push_back(32'h05000000);
        adr_q.push_back(9'h105); adr_q.push_back(9'h100);
        adr_q.push_back(9'h100); adr_q.push_back(9'h100);
        exp_q.push_back(24'h3C0105); exp_q.push_back(24'h3C0100);
        exp_q.push_back(24'h3C0100); exp_q.push_back(24'h3C0100);
        go(2'b00, 1'b1);
        drain("tclut");
        chk("tclut_latency", (wcyc.size() > 0 && rcyc.size() > 0) ? gap(rcyc[0], wcyc[0]) : -1, 6);
        chk("tclut_lookups_done", adr_q.size(), 0);

        // 8bpp grey with a 4-cycle line-FIFO stall after the first pixel
        stop_video();
        wq.push_back(32'h01020304);
        exp_q.push_back(24'h010101); exp_q.push_back(24'h020202);
        exp_q.push_back(24'h030303); exp_q.push_back(24'h040404);
        go(2'b00, 1'b0);
        t = 0;
        while (!pix_wreq_o && t < 50) begin @(negedge clk_i); t++; end
        @(posedge clk_i); #1;
        pix_full_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        pix_full_i = 1'b0;
        drain("tstall");
        chk("tstall_count", wcyc.size(), 4);
        chk("tstall_span", (wcyc.size() == 4) ? gap(wcyc[0], wcyc[3]) : -1, 7);

        // Disable during a CLUT wait, late ack, then restart in 24bpp
        stop_video();
        ack_delay = 10;
        wq.push_back(32'h07000000);
        adr_q.push_back(9'h107);
        go(2'b00, 1'b1);
        t = 0;
        while (!clut_req_o && t < 50) begin @(negedge clk_i); t++; end
        chk("tdrop_req_seen", {31'h0, clut_req_o}, 1);
        @(posedge clk_i); #1;
        ctrl_ven = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("tdrop_req_off",  {31'h0, clut_req_o},  0);
        chk("tdrop_rreq_off", {31'h0, vdat_rreq_o}, 0);
        adr_q.delete();
        w0 = n_wreq;
        @(posedge clk_i); #1;
        force_ack = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("tdrop_late_ack_no_pixel", n_wreq - w0, 0);
        ack_delay = 3;
        wq.push_back(32'hA1B2C3D4); wq.push_back(32'hE5F60718); wq.push_back(32'h293A4B5C);
        exp_q.push_back(24'hA1B2C3); exp_q.push_back(24'hD4E5F6);
        exp_q.push_back(24'h071829); exp_q.push_back(24'h3A4B5C);
        @(posedge clk_i); #1;
        go(2'b10, 1'b0);
        drain("trestart24");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
